uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max clkI cycles WAIT_BUSY waits for tx_busy before aborting.
REQ-002 clkI  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clkI rising edge.
REQ-004 req_valid  input  3  per-requester send request; index 0..2.
REQ-005 req_data  input  24  requester i byte on bits [8i+7:8i].
REQ-006 req_ready  output  3  one-hot, one-cycle accept pulse to the granted requester.
REQ-007 cfg_we  input  1  config write strobe.
REQ-008 cfg_baud  input  2  new baud_rate value, captured on cfg_we.
REQ-009 cfg_parity  input  2  new parity_type value, captured on cfg_we.
REQ-010 tx_busy  input  1  UART transmitter busy from shifting start bit through stop bit.
REQ-011 tx_start  output  1  one-cycle pulse launching the transmitter.
REQ-012 tx_data  output  8  byte presented to transmitter; stable from tx_start until next grant.
REQ-013 baud_rate  output  2  applied baud select to UART.
REQ-014 parity_type  output  2  applied parity select to UART.
REQ-015 grant_id  output  2  index of current owner; 2'b11 = none.
REQ-016 cfg_pending  output  1  shadow config waiting to be applied.
REQ-017 err_timeout  output  1  sticky flag: transmitter failed to assert tx_busy within TIMEOUT.

Function
REQ-018 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, CFG; all outputs registered.
REQ-019 cfg_we in any state: cfg_baud/cfg_parity latched to shadow, cfg_pending=1 next cycle; later write before apply overwrites (last wins).
REQ-020 IDLE with cfg_pending=1: go to CFG (config has priority over data requests).
REQ-021 CFG (one cycle): baud_rate/parity_type <= shadow, cfg_pending <= 0, -> IDLE; a cfg_we in this same cycle re-captures shadow and leaves cfg_pending=1.
REQ-022 Config outputs never change in START, WAIT_BUSY, WAIT_DONE (no mid-frame reconfiguration).
REQ-023 IDLE, cfg_pending=0, any req_valid: round-robin select, search order last_grant+1, +2, +3 mod 3.
REQ-024 Grant edge: tx_data <= selected byte, grant_id <= index, last_grant <= index, -> START.
REQ-025 START (one cycle): tx_start=1 and req_ready[grant_id]=1 together; -> WAIT_BUSY; latency req_valid sampled -> tx_start = 1 cycle.
REQ-026 Requesters hold req_valid and req_data until req_ready; dropping req_valid before grant cancels without side effects.
REQ-027 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; counter reaches TIMEOUT with tx_busy=0 -> err_timeout=1, grant_id=2'b11, -> IDLE.
REQ-028 WAIT_DONE: tx_busy=0 -> IDLE, grant_id=2'b11; no new grant in the cycle tx_busy falls.
REQ-029 Single requester continuously valid gets back-to-back frames; with all three valid, grants rotate 0,1,2,0.
REQ-030 err_timeout cleared only by reset.

Reset
REQ-031 reset=1 at an edge, any state: state=IDLE, tx_start=0, req_ready=0, tx_data=0, grant_id=2'b11, last_grant=2, baud_rate=2'b11, parity_type=2'b00, shadow=2'b11/2'b00, cfg_pending=0, err_timeout=0, counter=0.
REQ-032 Reset mid-frame abandons the frame; the requester receives no extra req_ready pulse.

Verification
REQ-033 Reset, req_valid=3'b001, req_data[7:0]=8'h55 -> next cycle tx_start=1, req_ready=3'b001, tx_data=8'h55, grant_id=0.
REQ-034 All valid, data 8'hA0/8'hA1/8'hA2, tx_busy model 10 cycles -> tx_data sequence A0,A1,A2,A0, one frame per busy window.
REQ-035 cfg_we with 2'b01/2'b10 during WAIT_DONE -> cfg_pending=1, baud_rate stays 2'b11 until tx_busy falls, then CFG applies 2'b01/2'b10 before next grant.
REQ-036 Two cfg_we (2'b00 then 2'b10) before IDLE -> only 2'b10 applied.
REQ-037 tx_busy held 0 after tx_start -> err_timeout=1 exactly TIMEOUT=16 cycles into WAIT_BUSY, grant_id=2'b11.
REQ-038 reset asserted in WAIT_DONE -> all outputs at REQ-031 values next cycle; pending request regranted from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets three requesters share one UART transmitter.
// Baud/parity changes are held in a shadow copy and applied only between frames.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clkI,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_baud,
    input  logic [1:0]  cfg_parity,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [1:0]  baud_rate,
    output logic [1:0]  parity_type,
    output logic [1:0]  grant_id,
    output logic        cfg_pending,
    output logic        err_timeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] CFG       = 3'd4;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic [1:0]    last_grant;
    logic [1:0]    shadow_baud;
    logic [1:0]    shadow_parity;
    logic [CW-1:0] counter;

    logic [3:0]    valid_ext;
    logic [1:0]    first_idx;
    logic [1:0]    second_idx;
    logic [1:0]    third_idx;
    logic [1:0]    sel_id;
    logic          sel_found;
    logic [7:0]    sel_byte;
    logic [2:0]    sel_onehot;

    // Search starts just after the previous owner and wraps modulo 3.
    always_comb begin
        valid_ext = {1'b0, req_valid};
        case (last_grant)
            2'd0:    {first_idx, second_idx, third_idx} = {2'd1, 2'd2, 2'd0};
            2'd1:    {first_idx, second_idx, third_idx} = {2'd2, 2'd0, 2'd1};
            default: {first_idx, second_idx, third_idx} = {2'd0, 2'd1, 2'd2};
        endcase
        sel_found = |req_valid;
        if (valid_ext[first_idx]) begin
            sel_id = first_idx;
        end else if (valid_ext[second_idx]) begin
            sel_id = second_idx;
        end else begin
            sel_id = third_idx;
        end
        case (sel_id)
            2'd1:    sel_byte = req_data[15:8];
            2'd2:    sel_byte = req_data[23:16];
            default: sel_byte = req_data[7:0];
        endcase
        sel_onehot = 3'b001 << sel_id;
    end

    always_ff @(posedge clkI) begin
        if (reset) begin
            state         <= IDLE;
            tx_start      <= 1'b0;
            req_ready     <= 3'b000;
            tx_data       <= 8'h00;
            grant_id      <= 2'b11;
            last_grant    <= 2'd2;
            baud_rate     <= 2'b11;
            parity_type   <= 2'b00;
            shadow_baud   <= 2'b11;
            shadow_parity <= 2'b00;
            cfg_pending   <= 1'b0;
            err_timeout   <= 1'b0;
            counter       <= '0;
        end else begin
            tx_start  <= 1'b0;
            req_ready <= 3'b000;

            // A write in any state, including CFG, leaves the newest value pending.
            if (cfg_we) begin
                shadow_baud   <= cfg_baud;
                shadow_parity <= cfg_parity;
                cfg_pending   <= 1'b1;
            end else if (state == CFG) begin
                cfg_pending   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_pending) begin
                        state <= CFG;
                    end else if (sel_found) begin
                        tx_data    <= sel_byte;
                        grant_id   <= sel_id;
                        last_grant <= sel_id;
                        tx_start   <= 1'b1;
                        req_ready  <= sel_onehot;
                        state      <= START;
                    end
                end
                START: begin
                    counter <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (counter == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        grant_id    <= 2'b11;
                        counter     <= '0;
                        state       <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_id <= 2'b11;
                        state    <= IDLE;
                    end
                end
                CFG: begin
                    baud_rate   <= shadow_baud;
                    parity_type <= shadow_parity;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
